// File: rtl/tlc_pkg.sv
// Shared state type, light encodings and duration helper for traffic_light_ctrl_multi.
// The EMERG state is only present when TLC_EMERGENCY_EN is defined.
package tlc_pkg;

    typedef enum logic [2:0] {
        StHwG,
        StHwY,
        StAr1,
        StSdG,
        StSdY,
`ifdef TLC_EMERGENCY_EN
        StAr2,
        StEmerg
`else
        StAr2
`endif
    } tlc_state_e;

    localparam logic [2:0] LIGHT_GREEN  = 3'b100;
    localparam logic [2:0] LIGHT_YELLOW = 3'b010;
    localparam logic [2:0] LIGHT_RED    = 3'b001;

    function automatic int unsigned max_dur(input int unsigned a, input int unsigned b,
                                            input int unsigned c, input int unsigned d);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/tlc_rr_arbiter.sv
// Combinational round-robin selector: first requesting road at or after ptr, wrapping.
// With no request the grant falls back to ptr itself.
module tlc_rr_arbiter #(
    parameter int unsigned NUM_SIDE = 2,
    parameter int unsigned PTR_W    = (NUM_SIDE > 1) ? $clog2(NUM_SIDE) : 1
) (
    input  logic [NUM_SIDE-1:0] req,
    input  logic [PTR_W-1:0]    ptr,
    output logic [PTR_W-1:0]    grant,
    output logic                any_req
);

    logic found_hi;

    always_comb begin
        grant    = ptr;
        found_hi = 1'b0;
        any_req  = |req;
        // Descending scans so the lowest qualifying index is the one left standing.
        for (int i = NUM_SIDE - 1; i >= 0; i--) begin
            if (req[i] && (PTR_W'(i) >= ptr)) begin
                grant    = PTR_W'(i);
                found_hi = 1'b1;
            end
        end
        if (!found_hi) begin
            for (int i = NUM_SIDE - 1; i >= 0; i--) begin
                if (req[i]) grant = PTR_W'(i);
            end
        end
    end

endmodule

// File: rtl/traffic_light_ctrl_multi.sv
// Highway / multi-local-road intersection controller with round-robin side service.
// Optional TLC_EMERGENCY_EN adds the emergency input and an all-red EMERG hold.
module traffic_light_ctrl_multi
    import tlc_pkg::*;
#(
    parameter int unsigned NUM_SIDE     = 2,
    parameter int unsigned HW_GREEN_MIN = 70,
    parameter int unsigned SIDE_GREEN   = 70,
    parameter int unsigned YELLOW       = 25,
    parameter int unsigned ALL_RED      = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_SIDE-1:0]   side_has_car,
`ifdef TLC_EMERGENCY_EN
    input  logic                  emergency,
`endif
    output logic [2:0]            hw_light,
    output logic [3*NUM_SIDE-1:0] side_light
);

    localparam int unsigned MaxDur = max_dur(HW_GREEN_MIN, SIDE_GREEN, YELLOW, ALL_RED);
    localparam int unsigned CntW   = (MaxDur > 1) ? $clog2(MaxDur) : 1;
    localparam int unsigned PtrW   = (NUM_SIDE > 1) ? $clog2(NUM_SIDE) : 1;

    localparam logic [CntW-1:0] CntMax    = CntW'(MaxDur - 1);
    localparam logic [CntW-1:0] HwMinLast = CntW'(HW_GREEN_MIN - 1);
    localparam logic [CntW-1:0] SdGLast   = CntW'(SIDE_GREEN - 1);
    localparam logic [CntW-1:0] YelLast   = CntW'(YELLOW - 1);
    localparam logic [CntW-1:0] ArLast    = CntW'(ALL_RED - 1);
    localparam logic [PtrW-1:0] PtrLast   = PtrW'(NUM_SIDE - 1);

    tlc_state_e      state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [PtrW-1:0] ptr_q, ptr_d;
    logic [PtrW-1:0] grant_q, grant_d;
    logic [PtrW-1:0] arb_grant, next_ptr;
    logic            arb_any;
    logic            emerg_req;

`ifdef TLC_EMERGENCY_EN
    assign emerg_req = emergency;
`else
    assign emerg_req = 1'b0;
`endif

    tlc_rr_arbiter #(
        .NUM_SIDE (NUM_SIDE),
        .PTR_W    (PtrW)
    ) u_arb (
        .req     (side_has_car),
        .ptr     (ptr_q),
        .grant   (arb_grant),
        .any_req (arb_any)
    );

    assign next_ptr = (arb_grant == PtrLast) ? '0 : arb_grant + PtrW'(1);

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        ptr_d   = ptr_q;
        unique case (state_q)
            StHwG: begin
                if (emerg_req || ((cnt_q >= HwMinLast) && arb_any)) state_d = StHwY;
            end
            StHwY: begin
                if (cnt_q == YelLast) begin
                    state_d = StAr1;
                    grant_d = arb_grant;
                    if (arb_any) ptr_d = next_ptr;
`ifdef TLC_EMERGENCY_EN
                    if (emergency) begin
                        state_d = StEmerg;
                        grant_d = grant_q;
                        ptr_d   = ptr_q;
                    end
`endif
                end
            end
            StAr1: begin
                if (cnt_q == ArLast) state_d = StSdG;
`ifdef TLC_EMERGENCY_EN
                if (emergency) state_d = StEmerg;
`endif
            end
            StSdG: begin
                if (emerg_req || (cnt_q == SdGLast)) state_d = StSdY;
            end
            StSdY: begin
                if (cnt_q == YelLast) state_d = StAr2;
`ifdef TLC_EMERGENCY_EN
                if ((cnt_q == YelLast) && emergency) state_d = StEmerg;
`endif
            end
            StAr2: begin
                if (cnt_q == ArLast) state_d = StHwG;
`ifdef TLC_EMERGENCY_EN
                if (emergency) state_d = StEmerg;
`endif
            end
`ifdef TLC_EMERGENCY_EN
            StEmerg: begin
                if (!emergency) state_d = StAr2;
            end
`endif
            default: state_d = StHwG;
        endcase
    end

    // Counter restarts on every state change and parks at the longest duration.
    always_comb begin
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (cnt_q == CntMax) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StHwG;
            cnt_q   <= '0;
            ptr_q   <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
        end
    end

    always_comb begin
        hw_light = LIGHT_RED;
        if (state_q == StHwG) hw_light = LIGHT_GREEN;
        if (state_q == StHwY) hw_light = LIGHT_YELLOW;
        for (int i = 0; i < NUM_SIDE; i++) begin
            side_light[3*i +: 3] = LIGHT_RED;
            if (grant_q == PtrW'(i)) begin
                if (state_q == StSdG) side_light[3*i +: 3] = LIGHT_GREEN;
                if (state_q == StSdY) side_light[3*i +: 3] = LIGHT_YELLOW;
            end
        end
    end

endmodule
